// File: rtl/noc_pkg.sv
// Shared flit format, state encodings and helpers for the NoC link adapter.
package noc_pkg;

    localparam int FLIT_W = 34;
    localparam int CORE_W = 16;

    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    typedef struct packed {
        logic [1:0]  typ;
        logic [31:0] payload;
    } flit_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_HEAD = 2'd2,
        T_TAIL = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        R_HEAD  = 2'd0,
        R_TAIL  = 2'd1,
        R_WRITE = 2'd2
    } rx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/noc_rx_reassembler.sv
// Rebuilds 2-flit packets from the router into {src, data} CPU-in FIFO entries
// and counts malformed flits.
module noc_rx_reassembler
    import noc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] rx_flit,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              rx_fifo_full,
    output logic [63:0]       rx_fifo_wdata,
    output logic              rx_fifo_wr,
    output logic [7:0]        rx_err_count
);

    rx_state_e          state_q, state_d;
    logic [CORE_W-1:0]  src_q, src_d;
    logic [31:0]        data_q, data_d;
    logic [7:0]         err_q, err_d;
    flit_t              flit;
    logic               xfer;

    assign flit          = flit_t'(rx_flit);
    assign rx_ready      = !reset && (state_q != R_WRITE);
    assign xfer          = rx_valid && rx_ready;
    assign rx_fifo_wr    = (state_q == R_WRITE) && !rx_fifo_full;
    assign rx_fifo_wdata = {16'd0, src_q, data_q};
    assign rx_err_count  = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= R_HEAD;
            src_q   <= '0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            R_HEAD: if (xfer) begin
                if (flit.typ == FLIT_HEAD) begin
                    src_d   = flit.payload[CORE_W-1:0];
                    state_d = R_TAIL;
                end else begin
                    err_d = sat_inc8(err_q);
                end
            end
            R_TAIL: if (xfer) begin
                if (flit.typ == FLIT_TAIL) begin
                    data_d  = flit.payload;
                    state_d = R_WRITE;
                end else begin
                    // A repeated HEAD restarts the packet with the newer source.
                    if (flit.typ == FLIT_HEAD) src_d = flit.payload[CORE_W-1:0];
                    err_d = sat_inc8(err_q);
                end
            end
            R_WRITE: if (!rx_fifo_full) state_d = R_HEAD;
            default: state_d = R_HEAD;
        endcase
    end

endmodule

// File: rtl/noc_link_adapter.sv
// Router-side link adapter: serialises CPU-out FIFO entries into HEAD/TAIL
// packets and hands RX reassembly to noc_rx_reassembler.
module noc_link_adapter
    import noc_pkg::*;
#(
    parameter logic [CORE_W-1:0] SRC_ID = 16'd0,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_fifo_empty,
    input  logic [63:0]       tx_fifo_rdata,
    output logic              tx_fifo_rd,
    output logic [FLIT_W-1:0] tx_flit,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [FLIT_W-1:0] rx_flit,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              rx_fifo_full,
    output logic [63:0]       rx_fifo_wdata,
    output logic              rx_fifo_wr,
    output logic [CNT_W-1:0]  tx_pkt_count,
    output logic [7:0]        rx_err_count
);

    tx_state_e          state_q, state_d;
    logic [CORE_W-1:0]  dest_q, dest_d;
    logic [31:0]        data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign tx_pkt_count = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= T_IDLE;
            dest_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        tx_fifo_rd = 1'b0;
        tx_valid   = 1'b0;
        tx_flit    = '0;
        case (state_q)
            // Pop only from idle so at most one entry is ever in flight.
            T_IDLE: if (!reset && !tx_fifo_empty) begin
                tx_fifo_rd = 1'b1;
                state_d    = T_LOAD;
            end
            T_LOAD: begin
                dest_d  = tx_fifo_rdata[47:32];
                data_d  = tx_fifo_rdata[31:0];
                state_d = T_HEAD;
            end
            T_HEAD: begin
                tx_valid = 1'b1;
                tx_flit  = {FLIT_HEAD, dest_q, SRC_ID};
                if (tx_ready) state_d = T_TAIL;
            end
            T_TAIL: begin
                tx_valid = 1'b1;
                tx_flit  = {FLIT_TAIL, data_q};
                if (tx_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = T_IDLE;
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

    noc_rx_reassembler u_rx (
        .clk           (clk),
        .reset         (reset),
        .rx_flit       (rx_flit),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_fifo_full  (rx_fifo_full),
        .rx_fifo_wdata (rx_fifo_wdata),
        .rx_fifo_wr    (rx_fifo_wr),
        .rx_err_count  (rx_err_count)
    );

endmodule

// File: tb/tb_noc_link_adapter.sv
// Scoreboard bench: stimulus queues expected flits/writes, a negedge monitor checks them.
module tb_noc_link_adapter;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_fifo_empty;
    logic [63:0] tx_fifo_rdata;
    logic        tx_fifo_rd;
    logic [33:0] tx_flit;
    logic        tx_valid;
    logic        tx_ready;
    logic [33:0] rx_flit;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_fifo_full;
    logic [63:0] rx_fifo_wdata;
    logic        rx_fifo_wr;
    logic [15:0] tx_pkt_count;
    logic [7:0]  rx_err_count;

    always #5 clk = ~clk;

    noc_link_adapter #(.SRC_ID(16'd3), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_rdata (tx_fifo_rdata),
        .tx_fifo_rd    (tx_fifo_rd),
        .tx_flit       (tx_flit),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_flit       (rx_flit),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_fifo_full  (rx_fifo_full),
        .rx_fifo_wdata (rx_fifo_wdata),
        .rx_fifo_wr    (rx_fifo_wr),
        .tx_pkt_count  (tx_pkt_count),
        .rx_err_count  (rx_err_count)
    );

    // CPU-out FIFO model: head appears the cycle after the pop strobe.
    logic [63:0] fmem [16];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign tx_fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (tx_fifo_rd) begin
            tx_fifo_rdata <= fmem[rd_ptr % 16];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    logic [33:0] exp_tx [$];
    logic [63:0] exp_rx [$];
    int s_chk = 0, s_err = 0, m_chk = 0, m_err = 0;
    int rd_cnt = 0, cyc = 0, head_cyc = 0, tail_cyc = 0;

    initial begin
        logic        hold, in_flight;
        logic [33:0] held, e;
        logic [63:0] er;
        hold = 1'b0;
        in_flight = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                hold = 1'b0;
                in_flight = 1'b0;
            end else begin
                if (tx_fifo_rd) begin
                    rd_cnt++;
                    m_chk++;
                    if (in_flight) begin
                        m_err++;
                        $display("FAIL pop_in_flight act=1 exp=0 cyc=%0d", cyc);
                    end
                    in_flight = 1'b1;
                end
                if (hold) begin
                    m_chk++;
                    if (!tx_valid || tx_flit !== held) begin
                        m_err++;
                        $display("FAIL tx_hold act=%0b/%h exp=1/%h", tx_valid, tx_flit, held);
                    end
                end
                if (tx_valid && tx_ready) begin
                    m_chk++;
                    if (exp_tx.size() == 0) begin
                        m_err++;
                        $display("FAIL tx_unexpected act=%h exp=none", tx_flit);
                    end else begin
                        e = exp_tx.pop_front();
                        if (tx_flit !== e) begin
                            m_err++;
                            $display("FAIL tx_flit act=%h exp=%h", tx_flit, e);
                        end
                    end
                    if (tx_flit[33:32] == FLIT_TAIL) begin
                        in_flight = 1'b0;
                        tail_cyc = cyc;
                    end else begin
                        head_cyc = cyc;
                    end
                    hold = 1'b0;
                end else if (tx_valid) begin
                    hold = 1'b1;
                    held = tx_flit;
                end else begin
                    hold = 1'b0;
                end
                if (rx_fifo_wr) begin
                    m_chk++;
                    if (exp_rx.size() == 0) begin
                        m_err++;
                        $display("FAIL rx_unexpected act=%h exp=none", rx_fifo_wdata);
                    end else begin
                        er = exp_rx.pop_front();
                        if (rx_fifo_wdata !== er) begin
                            m_err++;
                            $display("FAIL rx_wdata act=%h exp=%h", rx_fifo_wdata, er);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        s_chk++;
        if (act !== exp) begin
            s_err++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic push_tx(input logic [63:0] d, input logic both);
        fmem[wr_ptr % 16] = d;
        wr_ptr++;
        exp_tx.push_back({FLIT_HEAD, d[47:32], 16'd3});
        if (both) exp_tx.push_back({FLIT_TAIL, d[31:0]});
    endtask

    task automatic rx_send(input logic [1:0] t, input logic [31:0] p);
        int n = 0;
        rx_flit  = {t, p};
        rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_ready) break;
            if (++n > 50) begin
                chk("rx_send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!tx_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wait_tx_valid", 64'(tx_valid), 64'd1);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (tx_pkt_count != 16'(v) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("tx_pkt_count", 64'(tx_pkt_count), 64'(v));
    endtask

    initial begin
        reset = 1'b1;
        tx_ready = 1'b1;
        rx_flit = '0;
        rx_valid = 1'b0;
        rx_fifo_full = 1'b0;

        // Entry waiting during reset must not be popped.
        push_tx(64'h0000_0005_DEAD_BEEF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_fifo_rd", 64'(tx_fifo_rd), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_flit", 64'(tx_flit), 64'd0);
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_rx_fifo_wr", 64'(rx_fifo_wr), 64'd0);
        chk("rst_rx_wdata", rx_fifo_wdata, 64'd0);
        chk("rst_tx_cnt", 64'(tx_pkt_count), 64'd0);
        chk("rst_rx_err", 64'(rx_err_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic packet, router always ready.
        wait_cnt(1);
        chk("t1_pops", 64'(rd_cnt), 64'd1);
        chk("t1_back_to_back", 64'(tail_cyc - head_cyc), 64'd1);

        // HEAD stalled 5 cycles; a second entry is queued behind it.
        @(posedge clk); #1;
        tx_ready = 1'b0;
        push_tx(64'hABCD_00A0_CAFE_F00D, 1'b1);
        push_tx(64'h0000_0011_0000_0042, 1'b1);
        wait_valid();
        chk("t2_head_flit", 64'(tx_flit), 64'h1_00A0_0003);
        repeat (5) @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_cnt(3);
        chk("t2_pops", 64'(rd_cnt), 64'd3);

        // Clean RX packet.
        @(posedge clk); #1;
        exp_rx.push_back(64'h0000_0007_1234_5678);
        rx_send(FLIT_HEAD, 32'h0000_0007);
        rx_send(FLIT_TAIL, 32'h1234_5678);
        @(negedge clk);
        chk("t3_ready_in_write", 64'(rx_ready), 64'd0);
        @(negedge clk);
        chk("t3_ready_after", 64'(rx_ready), 64'd1);

        // RX with CPU-in FIFO full for 4 cycles.
        @(posedge clk); #1;
        rx_fifo_full = 1'b1;
        exp_rx.push_back(64'h0000_0007_1234_5678);
        rx_send(FLIT_HEAD, 32'h0000_0007);
        rx_send(FLIT_TAIL, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_stall_wr", 64'(rx_fifo_wr), 64'd0);
            chk("t4_stall_ready", 64'(rx_ready), 64'd0);
            chk("t4_stall_wdata", rx_fifo_wdata, 64'h0000_0007_1234_5678);
        end
        @(posedge clk); #1;
        rx_fifo_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_ready_after", 64'(rx_ready), 64'd1);
        chk("t4_rx_err", 64'(rx_err_count), 64'd0);

        // Malformed traffic.
        @(posedge clk); #1;
        rx_send(FLIT_TAIL, 32'h0000_0001);
        chk("t5_tail_in_head", 64'(rx_err_count), 64'd1);
        exp_rx.push_back(64'h0000_0009_AAAA_5555);
        rx_send(FLIT_HEAD, 32'h0000_0002);
        rx_send(FLIT_HEAD, 32'h0000_0009);
        rx_send(FLIT_TAIL, 32'hAAAA_5555);
        repeat (2) @(negedge clk);
        chk("t5_double_head", 64'(rx_err_count), 64'd2);
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) rx_send((i % 2 == 0) ? 2'b00 : 2'b10, 32'(i));
        chk("t5_err_saturate", 64'(rx_err_count), 64'd255);

        // Reset with TX mid-TAIL and RX mid-WRITE.
        tx_ready = 1'b0;
        push_tx(64'h0000_0021_0BAD_F00D, 1'b0);
        wait_valid();
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        rx_fifo_full = 1'b1;
        rx_send(FLIT_HEAD, 32'h0000_0005);
        rx_send(FLIT_TAIL, 32'h0000_0001);
        @(negedge clk);
        chk("t6_pre_tail", 64'(tx_flit), 64'h3_0BAD_F00D);
        chk("t6_pre_write", 64'(rx_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("t6_rst_tx_flit", 64'(tx_flit), 64'd0);
        chk("t6_rst_rx_wr", 64'(rx_fifo_wr), 64'd0);
        chk("t6_rst_wdata", rx_fifo_wdata, 64'd0);
        chk("t6_rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("t6_rst_cnt", 64'(tx_pkt_count), 64'd0);
        chk("t6_rst_err", 64'(rx_err_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rx_fifo_full = 1'b0;
        tx_ready = 1'b1;
        push_tx(64'h0000_0004_7777_8888, 1'b1);
        exp_rx.push_back(64'h0000_000C_0000_9999);
        rx_send(FLIT_HEAD, 32'h0000_000C);
        rx_send(FLIT_TAIL, 32'h0000_9999);
        wait_cnt(1);
        chk("t6_post_err", 64'(rx_err_count), 64'd0);

        repeat (5) @(negedge clk);
        chk("exp_tx_drained", 64'(exp_tx.size()), 64'd0);
        chk("exp_rx_drained", 64'(exp_rx.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", s_chk + m_chk, s_err + m_err);
        $finish;
    end

endmodule

// File: doc/noc_link_adapter.md
Name: noc_link_adapter

Overview:
- Router-side neighbour of the core network interface; sits between the interface FIFOs and the mesh router port.
- TX path: pops 64-bit {dest_core[31:0], data[31:0]} entries from the interface's CPU-out FIFO and serialises each one into a 2-flit packet (header, tail) on a valid/ready link.
- RX path: reassembles 2-flit packets from the router and pushes {src_core, data} into the interface's CPU-in FIFO.

Parameters:
- SRC_ID, 16'd0, this node's core index; placed in every TX header.
- CNT_W, 16, width of tx_pkt_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_fifo_empty  in  1  CPU-out FIFO empty.
- tx_fifo_rdata  in  64  CPU-out FIFO head; valid the cycle after tx_fifo_rd.
- tx_fifo_rd  out  1  pop strobe to the CPU-out FIFO.
- tx_flit  out  34  {type[1:0], payload[31:0]}.
- tx_valid  out  1  tx_flit valid.
- tx_ready  in  1  router accepts tx_flit.
- rx_flit  in  34  incoming flit.
- rx_valid  in  1  rx_flit valid.
- rx_ready  out  1  adapter accepts rx_flit.
- rx_fifo_full  in  1  CPU-in FIFO full.
- rx_fifo_wdata  out  64  {16'd0, src[15:0], data[31:0]}.
- rx_fifo_wr  out  1  push strobe to the CPU-in FIFO.
- tx_pkt_count  out  CNT_W  packets fully sent.
- rx_err_count  out  8  malformed flits dropped.

Behaviour:
- Flit types:
  - 2'b01 HEAD: payload = {dest[15:0], src[15:0]}.
  - 2'b11 TAIL: payload = data.
  - 2'b00 and 2'b10 are invalid.
- Reset (async, any time): both FSMs return to idle and any in-flight packet is discarded. Outputs: tx_fifo_rd=0, tx_valid=0, tx_flit=0, rx_ready=0 while reset is high, rx_fifo_wr=0, rx_fifo_wdata=0, both counters 0.
- Handshake: a transfer occurs when valid && ready are both high on a clock edge. tx_valid and tx_flit stay stable until accepted, and tx_valid never drops without a transfer.
- TX FSM:
  - T_IDLE: if !tx_fifo_empty, assert tx_fifo_rd for exactly one cycle and go to T_LOAD.
  - T_LOAD: capture tx_fifo_rdata; dest = rdata[47:32] and rdata[63:48] is ignored. Go to T_HEAD.
  - T_HEAD: tx_valid=1, flit={01, dest, SRC_ID}. On transfer go to T_TAIL.
  - T_TAIL: tx_valid=1, flit={11, data}. On transfer, tx_pkt_count++ (wraps) and go to T_IDLE.
  - Minimum 4 cycles per packet. No pop while a packet is in flight, so FIFO order is preserved.
- RX FSM:
  - R_HEAD: rx_ready=1.
    - HEAD accepted: latch src=payload[15:0] and go to R_TAIL.
    - TAIL or invalid type accepted: drop it, rx_err_count++.
  - R_TAIL: rx_ready=1.
    - TAIL accepted: latch data and go to R_WRITE.
    - HEAD accepted: overwrite src, rx_err_count++, stay in R_TAIL.
    - Invalid type accepted: drop it, rx_err_count++, stay.
  - R_WRITE: rx_ready=0; rx_fifo_wr = !rx_fifo_full, combinational from the state.
    - When written: go to R_HEAD.
    - While full: hold, providing backpressure to the router.
    - rx_fifo_wdata is stable throughout R_WRITE.
- rx_err_count saturates at 255.
- Destination decode (dest != SRC_ID) is not checked here; the router delivers.
- TX and RX are fully independent; simultaneous activity is legal.

Decomposition:
- Shared package noc_pkg:
  - FLIT_W=34.
  - FLIT_HEAD=2'b01, FLIT_TAIL=2'b11.
  - TX/RX state encodings.
  - Core-index width 16.
- Sub-module noc_rx_reassembler for the RX FSM and error counter. TX stays in the top level.

Test Plan:
- Reset, then push {32'h0000_0005, 32'hDEAD_BEEF}, SRC_ID=3, tx_ready=1:
  - One tx_fifo_rd pulse.
  - HEAD flit 34'h1_0005_0003, then TAIL flit 34'h3_DEAD_BEEF on consecutive cycles.
  - tx_pkt_count=1.
- Same push with tx_ready low for 5 cycles during HEAD: tx_valid and the flit are held unchanged; after release the packet completes and there is no second pop.
- RX HEAD src=7, then TAIL 32'h1234_5678, with rx_fifo_full=0: one rx_fifo_wr carrying 64'h0000_0007_1234_5678, then rx_ready=1.
- Same RX sequence with rx_fifo_full=1 for 4 cycles: rx_ready=0 and no wr during the stall; a single wr follows the release.
- Malformed RX traffic:
  - TAIL in R_HEAD: rx_err_count=1, nothing written.
  - HEAD src=2 then HEAD src=9 then TAIL: err=2, wdata src field=9.
  - 300 bad flits: err holds at 255.
- Reset asserted mid-T_TAIL and mid-R_WRITE: outputs cleared asynchronously, no wr or flit completes, and the next packet is processed normally.
